uart_pwm_regbank: RTL and testbench

UART_PWM_REGBANK -- requirements
Module: uart_pwm_regbank

---
 rtl/pwm_regbank_pkg.sv | 39 +++
 rtl/pwm_ch_regs.sv | 51 +++++
 rtl/uart_pwm_regbank.sv | 169 ++++++++++++++++
 tb/tb_uart_pwm_regbank.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_regbank_pkg.sv
// Shared command/response codes, FSM states and channel field bundle
// for the UART-driven PWM register bank.
package pwm_regbank_pkg;

  localparam logic [7:0] FN_SET    = 8'h01;
  localparam logic [7:0] FN_LS     = 8'h02;
  localparam logic [7:0] FN_COMMIT = 8'h03;
  localparam logic [7:0] FN_READ   = 8'h04;
  localparam logic [7:0] FN_BCAST  = 8'h05;

  localparam logic [7:0] RC_ACK    = 8'h00;
  localparam logic [7:0] RC_UNK    = 8'hE1;
  localparam logic [7:0] RC_BADCH  = 8'hE2;
  localparam logic [7:0] RC_TMO    = 8'hE3;
  localparam logic [7:0] RC_NOMASK = 8'hE4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Field order mirrors frame bytes 2..6
  typedef struct packed {
    logic [7:0]  hs_ctrl;
    logic [7:0]  duty;
    logic [15:0] dessert;
    logic [7:0]  pulse_num;
  } ch_cfg_t;

  function automatic logic [7:0] frame_byte(
    input logic [87:0] d,
    input int          n
  );
    return d[95-8*n -: 8];
  endfunction

endpackage

// File: rtl/pwm_ch_regs.sv
// One PWM channel: shadow registers loaded by commands, active copy
// updated from shadow on a commit strobe.
module pwm_ch_regs
  import pwm_regbank_pkg::*;
#(
  parameter int PW = 32
) (
  input  logic          clk_50M,
  input  logic          rst_n,
  input  logic          ld_hs_i,
  input  logic          ld_ls_i,
  input  logic          commit_i,
  input  ch_cfg_t       cfg_i,
  input  logic [7:0]    ls_i,
  input  logic [PW-1:0] pat_i,
  output ch_cfg_t       cfg_o,
  output logic [7:0]    ls_o,
  output logic [PW-1:0] pat_o
);

  ch_cfg_t       sh_cfg_q, act_cfg_q;
  logic [7:0]    sh_ls_q, act_ls_q;
  logic [PW-1:0] sh_pat_q, act_pat_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sh_cfg_q  <= '0;
      sh_ls_q   <= '0;
      sh_pat_q  <= '0;
      act_cfg_q <= '0;
      act_ls_q  <= '0;
      act_pat_q <= '0;
    end else begin
      if (ld_hs_i) begin
        sh_cfg_q <= cfg_i;
        sh_pat_q <= pat_i;
      end
      if (ld_ls_i) sh_ls_q <= ls_i;
      if (commit_i) begin
        act_cfg_q <= sh_cfg_q;
        act_ls_q  <= sh_ls_q;
        act_pat_q <= sh_pat_q;
      end
    end
  end

  assign cfg_o = act_cfg_q;
  assign ls_o  = act_ls_q;
  assign pat_o = act_pat_q;

endmodule

// File: rtl/uart_pwm_regbank.sv
// UART command frames -> double-buffered PWM channel registers.
// Define REGBANK_READBACK_EN to enable the 0x04 readback command.
module uart_pwm_regbank
  import pwm_regbank_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int PAT_WIDTH  = 32,
  parameter int COMMIT_TMO = 1048575
) (
  input  logic                          clk_50M,
  input  logic                          rst_n,
  input  logic                          pack_done,
  input  logic [7:0]                    func_reg,
  input  logic [87:0]                   rev_data,
  input  logic [NUM_CH-1:0]             ch_busy,
  output logic [NUM_CH-1:0]             hs_en,
  output logic [8*NUM_CH-1:0]           duty_num,
  output logic [8*NUM_CH-1:0]           pulse_num,
  output logic [8*NUM_CH-1:0]           ls_ctrl,
  output logic [16*NUM_CH-1:0]          pulse_dessert,
  output logic [PAT_WIDTH*NUM_CH-1:0]   pat,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [7:0]                    resp_code,
  output logic [31:0]                   resp_data,
  output logic                          cmd_busy,
  output logic [7:0]                    drop_cnt
);

  localparam int TW = $clog2(COMMIT_TMO + 1);

  state_t                 state_q, state_d;
  logic [7:0]             func_q;
  logic [87:0]            data_q;
  logic [7:0]             code_q, code_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [TW-1:0]          tmo_q;
  logic [7:0]             drop_q;
  logic [NUM_CH-1:0]      ld_hs, ld_ls, commit;
  logic [NUM_CH-1:0]      mask;
  logic [7:0]             b1;
  logic                   ch_ok, busy_clr, tmo_hit;
  ch_cfg_t                cfg_new;
  logic [PAT_WIDTH-1:0]   pat_new;
  ch_cfg_t                act_cfg [NUM_CH];

  assign b1       = frame_byte(data_q, 1);
  assign ch_ok    = int'(b1) < NUM_CH;
  assign mask     = data_q[72 +: NUM_CH];
  assign busy_clr = (ch_busy & mask) == '0;
  assign tmo_hit  = tmo_q == TW'(COMMIT_TMO);
  // Bytes 2..6 land directly on the field bundle
  assign cfg_new  = data_q[79:40];
  assign pat_new  = data_q[8 +: PAT_WIDTH];

`ifdef REGBANK_READBACK_EN
  logic [31:0] rb;
  always_comb begin
    rb = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (b1 == 8'(i))
        rb = {act_cfg[i].duty, act_cfg[i].pulse_num,
              act_cfg[i].dessert};
  end
`endif

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      func_q  <= '0;
      data_q  <= '0;
      code_q  <= '0;
      rdata_q <= '0;
      tmo_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      rdata_q <= rdata_d;
      tmo_q   <= (state_q == ST_WAIT) ? tmo_q + 1'b1 : '0;
      if (state_q == ST_IDLE && pack_done) begin
        func_q <= func_reg;
        data_q <= rev_data;
      end
      if (pack_done && state_q != ST_IDLE && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: if (pack_done) state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = ST_RESP;
        code_d  = RC_ACK;
        rdata_d = '0;
        unique case (1'b1)
          func_q == FN_SET,
          func_q == FN_LS:
            if (!ch_ok) code_d = RC_BADCH;
          func_q == FN_BCAST: ;
          func_q == FN_COMMIT:
            if (mask == '0) code_d = RC_NOMASK;
            else state_d = ST_WAIT;
`ifdef REGBANK_READBACK_EN
          func_q == FN_READ:
            if (!ch_ok) code_d = RC_BADCH;
            else rdata_d = rb;
`endif
          default: code_d = RC_UNK;
        endcase
      end
      ST_WAIT:
        if (busy_clr) begin
          state_d = ST_RESP;
          code_d  = RC_ACK;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          code_d  = RC_TMO;
        end
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_hs  = '0;
    ld_ls  = '0;
    commit = '0;
    if (state_q == ST_DECODE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ld_hs[i] = (func_q == FN_SET && b1 == 8'(i))
                 || func_q == FN_BCAST;
        ld_ls[i] = func_q == FN_LS && b1 == 8'(i);
      end
    end
    if (state_q == ST_WAIT && busy_clr) commit = mask;
  end

  assign resp_valid = state_q == ST_RESP;
  assign cmd_busy   = state_q != ST_IDLE;
  assign resp_code  = code_q;
  assign resp_data  = rdata_q;
  assign drop_cnt   = drop_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_ch_regs #(.PW(PAT_WIDTH)) u_regs (
      .clk_50M  (clk_50M),
      .rst_n    (rst_n),
      .ld_hs_i  (ld_hs[i]),
      .ld_ls_i  (ld_ls[i]),
      .commit_i (commit[i]),
      .cfg_i    (cfg_new),
      .ls_i     (frame_byte(data_q, 2)),
      .pat_i    (pat_new),
      .cfg_o    (act_cfg[i]),
      .ls_o     (ls_ctrl[8*i +: 8]),
      .pat_o    (pat[PAT_WIDTH*i +: PAT_WIDTH])
    );
    assign hs_en[i]               = act_cfg[i].hs_ctrl[0];
    assign duty_num[8*i +: 8]     = act_cfg[i].duty;
    assign pulse_num[8*i +: 8]    = act_cfg[i].pulse_num;
    assign pulse_dessert[16*i +: 16] = act_cfg[i].dessert;
  end

endmodule

// File: tb/tb_uart_pwm_regbank.sv
// Randomised bench for uart_pwm_regbank with a channel-array reference
// model; a second instance with a short commit timeout covers the NAK path.
module tb_uart_pwm_regbank;

  localparam int NCH   = 8;
  localparam int PW    = 16;
  localparam int TMO   = 1000;
  localparam int TMO_S = 100;
  localparam int AW    = NCH * (1 + 24 + 16 + PW);

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic              rst_n, pack_done, resp_ready;
  logic [7:0]        func_reg;
  logic [87:0]       rev_data;
  logic [NCH-1:0]    ch_busy, ch_busy_t;

  logic [NCH-1:0]    hs_en, t_hs_en;
  logic [8*NCH-1:0]  duty_num, pulse_num, ls_ctrl;
  logic [8*NCH-1:0]  t_duty_num, t_pulse_num, t_ls_ctrl;
  logic [16*NCH-1:0] pulse_dessert, t_pulse_dessert;
  logic [PW*NCH-1:0] pat, t_pat;
  logic              resp_valid, t_resp_valid, cmd_busy, t_cmd_busy;
  logic [7:0]        resp_code, t_resp_code, drop_cnt, t_drop_cnt;
  logic [31:0]       resp_data, t_resp_data;

  uart_pwm_regbank #(.NUM_CH(NCH), .PAT_WIDTH(PW), .COMMIT_TMO(TMO)) u_dut (
    .clk_50M(clk), .rst_n(rst_n), .pack_done(pack_done),
    .func_reg(func_reg), .rev_data(rev_data), .ch_busy(ch_busy),
    .hs_en(hs_en), .duty_num(duty_num), .pulse_num(pulse_num),
    .ls_ctrl(ls_ctrl), .pulse_dessert(pulse_dessert), .pat(pat),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_code(resp_code), .resp_data(resp_data),
    .cmd_busy(cmd_busy), .drop_cnt(drop_cnt));

  uart_pwm_regbank #(.NUM_CH(NCH), .PAT_WIDTH(PW), .COMMIT_TMO(TMO_S)) u_tmo (
    .clk_50M(clk), .rst_n(rst_n), .pack_done(pack_done),
    .func_reg(func_reg), .rev_data(rev_data), .ch_busy(ch_busy_t),
    .hs_en(t_hs_en), .duty_num(t_duty_num), .pulse_num(t_pulse_num),
    .ls_ctrl(t_ls_ctrl), .pulse_dessert(t_pulse_dessert), .pat(t_pat),
    .resp_valid(t_resp_valid), .resp_ready(resp_ready),
    .resp_code(t_resp_code), .resp_data(t_resp_data),
    .cmd_busy(t_cmd_busy), .drop_cnt(t_drop_cnt));

  wire [AW-1:0] all_out =
    {hs_en, duty_num, pulse_num, ls_ctrl, pulse_dessert, pat};
  wire [AW-1:0] t_all_out =
    {t_hs_en, t_duty_num, t_pulse_num, t_ls_ctrl, t_pulse_dessert, t_pat};

  typedef struct packed {
    logic [7:0]  hs, duty, pn, ls;
    logic [15:0] des;
    logic [31:0] pat;
  } chm_t;

  chm_t sh [NCH];
  chm_t act[NCH];
  int   m_drop;
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [7:0] byte_of(input logic [87:0] d, input int n);
    return d[95-8*n -: 8];
  endfunction

  function automatic logic [87:0] rnd_frame(input logic [7:0] b1);
    logic [87:0] d;
    for (int k = 0; k < 11; k++) d[8*k +: 8] = 8'($urandom);
    d[87:80] = b1;
    return d;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NCH; i++) begin
      sh[i]  = '0;
      act[i] = '0;
    end
    m_drop = 0;
  endfunction

  function automatic void model_cmd(input logic [7:0] f,
                                    input logic [87:0] d,
                                    output logic [7:0] code,
                                    output logic [31:0] rd,
                                    output logic [NCH-1:0] cm);
    int c;
    c    = int'(byte_of(d, 1));
    code = 8'h00;
    rd   = '0;
    cm   = '0;
    case (f)
      8'h01, 8'h05: begin
        for (int i = 0; i < NCH; i++)
          if ((f == 8'h05) || (i == c)) begin
            sh[i].hs   = byte_of(d, 2);
            sh[i].duty = byte_of(d, 3);
            sh[i].des  = {byte_of(d, 4), byte_of(d, 5)};
            sh[i].pn   = byte_of(d, 6);
            sh[i].pat  = {byte_of(d, 7), byte_of(d, 8),
                          byte_of(d, 9), byte_of(d, 10)};
          end
        if (f == 8'h01 && c >= NCH) code = 8'hE2;
      end
      8'h02:
        if (c < NCH) sh[c].ls = byte_of(d, 2);
        else code = 8'hE2;
      8'h03: begin
        cm = d[72 +: NCH];
        if (cm == '0) code = 8'hE4;
      end
`ifdef REGBANK_READBACK_EN
      8'h04:
        if (c < NCH) rd = {act[c].duty, act[c].pn, act[c].des};
        else code = 8'hE2;
`endif
      default: code = 8'hE1;
    endcase
  endfunction

  function automatic void model_commit(input logic [NCH-1:0] m);
    for (int i = 0; i < NCH; i++) if (m[i]) act[i] = sh[i];
  endfunction

  function automatic logic [AW-1:0] e_all();
    logic [NCH-1:0]    h;
    logic [8*NCH-1:0]  du, pn, ls;
    logic [16*NCH-1:0] de;
    logic [PW*NCH-1:0] pa;
    for (int i = 0; i < NCH; i++) begin
      h[i]          = act[i].hs[0];
      du[8*i +: 8]  = act[i].duty;
      pn[8*i +: 8]  = act[i].pn;
      ls[8*i +: 8]  = act[i].ls;
      de[16*i +: 16] = act[i].des;
      pa[PW*i +: PW] = act[i].pat[PW-1:0];
    end
    return {h, du, pn, ls, de, pa};
  endfunction

  task automatic send(input logic [7:0] f, input logic [87:0] d,
                      input int budget, output logic [7:0] code,
                      output logic [31:0] rd, output int lat,
                      output bit to);
    func_reg  = f;
    rev_data  = d;
    pack_done = 1'b1;
    @(posedge clk); #1;
    pack_done = 1'b0;
    lat = 1;
    while (!resp_valid && lat < budget) begin
      @(posedge clk); #1;
      lat++;
    end
    to   = !resp_valid;
    code = resp_code;
    rd   = resp_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pack_done = 1'b0; resp_ready = 1'b1;
    func_reg = '0; rev_data = '0; ch_busy = '0; ch_busy_t = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_regs: got %h want 0", all_out);
    end
    n_chk++;
    if ({resp_valid, cmd_busy, drop_cnt, resp_code, resp_data} !== '0) begin
      n_err++;
      $display("FAIL reset_ctl: valid=%b busy=%b drop=%h code=%h data=%h want 0",
               resp_valid, cmd_busy, drop_cnt, resp_code, resp_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (resp_valid !== 1'b0 || cmd_busy !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset: valid=%b busy=%b want 0 0",
                        resp_valid, cmd_busy);
    end
  endtask

  task automatic test_set_commit();
    logic [87:0] d; logic [7:0] ec, code; logic [31:0] er, rd;
    logic [NCH-1:0] cm; int lat; bit to;
    d = rnd_frame(8'd2);
    d[71:64] = 8'h10;
    model_cmd(8'h01, d, ec, er, cm);
    send(8'h01, d, 10, code, rd, lat, to);
    n_chk++;
    if (to || code !== ec || rd !== er || lat != 2) begin
      n_err++; $display("FAIL set_ack: code=%h data=%h lat=%0d want %h %h 2",
                        code, rd, lat, ec, er);
    end
    n_chk++;
    if (duty_num[23:16] !== 8'h00 || all_out !== e_all()) begin
      n_err++; $display("FAIL set_no_effect: duty2=%h want 00", duty_num[23:16]);
    end
    d = rnd_frame(8'h00);
    d[79:72] = 8'h04;
    model_cmd(8'h03, d, ec, er, cm);
    send(8'h03, d, 10, code, rd, lat, to);
    model_commit(cm);
    n_chk++;
    if (to || code !== 8'h00 || rd !== 32'h0 || lat != 3) begin
      n_err++; $display("FAIL commit_ack: code=%h data=%h lat=%0d want 00 0 3",
                        code, rd, lat);
    end
    n_chk++;
    if (duty_num[23:16] !== 8'h10 || all_out !== e_all()) begin
      n_err++; $display("FAIL commit_apply: got %h want %h", all_out, e_all());
    end
  endtask

  task automatic test_errors();
    logic [7:0] fn[8] = '{8'h01, 8'h02, 8'h04, 8'h7F, 8'h03, 8'h03, 8'h00, 8'h06};
    logic [7:0] b1[8] = '{8'(NCH), 8'hC8, 8'(NCH), 8'h00, 8'h00, 8'h01, 8'h03, 8'h01};
    logic [87:0] d; logic [7:0] ec, code; logic [31:0] er, rd;
    logic [NCH-1:0] cm; int lat; bit to;
    for (int i = 0; i < 8; i++) begin
      d = rnd_frame(b1[i]);
      if (fn[i] == 8'h03) d[79:72] = 8'h00;
      model_cmd(fn[i], d, ec, er, cm);
      send(fn[i], d, 10, code, rd, lat, to);
      n_chk++;
      if (to || code !== ec || rd !== er || lat != 2) begin
        n_err++; $display("FAIL nak_%0d: func=%h code=%h lat=%0d want %h 2",
                          i, fn[i], code, lat, ec);
      end
    end
    d = rnd_frame(8'hFF);
    d[79:72] = 8'hFF;
    model_cmd(8'h03, d, ec, er, cm);
    send(8'h03, d, 10, code, rd, lat, to);
    model_commit(cm);
    n_chk++;
    if (to || code !== 8'h00 || all_out !== e_all()) begin
      n_err++; $display("FAIL nak_no_change: code=%h got %h want %h",
                        code, all_out, e_all());
    end
  endtask

  task automatic test_busy_wait();
    logic [87:0] d, dc; logic [7:0] ec, code; logic [31:0] er, rd;
    logic [NCH-1:0] cm; int lat; bit to, bad;
    d = rnd_frame(8'd2);
    d[71:64] = act[2].duty ^ 8'hA5;
    model_cmd(8'h01, d, ec, er, cm);
    send(8'h01, d, 10, code, rd, lat, to);
    dc = rnd_frame(8'h00);
    dc[79:72] = 8'h04;
    model_cmd(8'h03, dc, ec, er, cm);
    ch_busy = 8'h24;
    func_reg = 8'h03; rev_data = dc; pack_done = 1'b1;
    @(posedge clk); #1;
    pack_done = 1'b0;
    bad = 1'b0;
    repeat (500) begin
      @(posedge clk); #1;
      if (resp_valid || !cmd_busy || all_out !== e_all()) bad = 1'b1;
    end
    n_chk++;
    if (bad) begin
      n_err++; $display("FAIL busy_hold: valid=%b busy=%b want 0 1", resp_valid, cmd_busy);
    end
    ch_busy[2] = 1'b0;
    @(posedge clk); #1;
    model_commit(cm);
    n_chk++;
    if (resp_valid !== 1'b1 || resp_code !== 8'h00) begin
      n_err++; $display("FAIL busy_release_ack: valid=%b code=%h want 1 00",
                        resp_valid, resp_code);
    end
    n_chk++;
    if (all_out !== e_all()) begin
      n_err++; $display("FAIL busy_release_apply: got %h want %h", all_out, e_all());
    end
    @(posedge clk); #1;
    d = rnd_frame(8'd2);
    d[71:64] = act[2].duty ^ 8'h3C;
    model_cmd(8'h01, d, ec, er, cm);
    send(8'h01, d, 10, code, rd, lat, to);
    ch_busy = 8'hFB;
    model_cmd(8'h03, dc, ec, er, cm);
    send(8'h03, dc, 10, code, rd, lat, to);
    model_commit(cm);
    ch_busy = '0;
    n_chk++;
    if (to || code !== 8'h00 || lat != 3 || all_out !== e_all()) begin
      n_err++; $display("FAIL unmasked_busy: code=%h lat=%0d want 00 3", code, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [87:0] d; logic [7:0] ec, code; logic [31:0] er, rd;
    logic [NCH-1:0] cm; int lat; bit to, bad;
    resp_ready = 1'b0;
    d = rnd_frame(8'd1);
    model_cmd(8'h01, d, ec, er, cm);
    func_reg = 8'h01; rev_data = d; pack_done = 1'b1;
    @(posedge clk); #1;
    pack_done = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    bad = !resp_valid;
    for (int c = 0; c < 50; c++) begin
      if (c == 10 || c == 20 || c == 30) begin
        func_reg = 8'h05; rev_data = rnd_frame(8'h00); pack_done = 1'b1;
        m_drop++;
      end else pack_done = 1'b0;
      @(posedge clk); #1;
      if (!resp_valid || resp_code !== ec || resp_data !== er) bad = 1'b1;
    end
    pack_done = 1'b0;
    n_chk++;
    if (bad) begin
      n_err++; $display("FAIL resp_hold: valid=%b code=%h want 1 %h",
                        resp_valid, resp_code, ec);
    end
    n_chk++;
    if (drop_cnt !== 8'(m_drop)) begin
      n_err++; $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, m_drop);
    end
    pack_done = 1'b1;
    repeat (260) begin
      @(posedge clk);
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    end
    #1;
    pack_done = 1'b0;
    n_chk++;
    if (drop_cnt !== 8'(m_drop)) begin
      n_err++; $display("FAIL drop_sat: got %0d want %0d", drop_cnt, m_drop);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (resp_valid !== 1'b0 || cmd_busy !== 1'b0) begin
      n_err++; $display("FAIL resp_release: valid=%b busy=%b want 0 0",
                        resp_valid, cmd_busy);
    end
    d = rnd_frame(8'hFF);
    d[79:72] = 8'hFF;
    model_cmd(8'h03, d, ec, er, cm);
    send(8'h03, d, 10, code, rd, lat, to);
    model_commit(cm);
    n_chk++;
    if (to || code !== 8'h00 || all_out !== e_all()) begin
      n_err++; $display("FAIL drop_no_load: got %h want %h", all_out, e_all());
    end
  endtask

  task automatic test_broadcast_readback();
    logic [7:0] rb_ch[3] = '{8'h00, 8'(NCH-1), 8'(NCH)};
    logic [87:0] d; logic [7:0] ec, code; logic [31:0] er, rd;
    logic [NCH-1:0] cm; int lat; bit to;
    d = rnd_frame(8'($urandom));
    model_cmd(8'h05, d, ec, er, cm);
    send(8'h05, d, 10, code, rd, lat, to);
    n_chk++;
    if (to || code !== 8'h00 || lat != 2) begin
      n_err++; $display("FAIL bcast_ack: code=%h lat=%0d want 00 2", code, lat);
    end
    d = rnd_frame(8'hFF);
    d[79:72] = 8'hFF;
    model_cmd(8'h03, d, ec, er, cm);
    send(8'h03, d, 10, code, rd, lat, to);
    model_commit(cm);
    n_chk++;
    if (to || code !== 8'h00 || all_out !== e_all()) begin
      n_err++; $display("FAIL bcast_apply: got %h want %h", all_out, e_all());
    end
    for (int i = 0; i < 3; i++) begin
      d = rnd_frame(rb_ch[i]);
      model_cmd(8'h04, d, ec, er, cm);
      send(8'h04, d, 10, code, rd, lat, to);
      n_chk++;
      if (to || code !== ec || rd !== er || lat != 2) begin
        n_err++; $display("FAIL readback_%0d: code=%h data=%h want %h %h",
                          i, code, rd, ec, er);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] fl[6] = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [87:0] d; logic [7:0] f, ec, code; logic [31:0] er, rd;
    logic [NCH-1:0] cm; int lat, el, r; bit to;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 6);
      f = (r < 6) ? fl[r] : 8'($urandom);
      d = rnd_frame(8'($urandom_range(0, 9)));
      if (f == 8'h03 && $urandom_range(0, 3) == 0) d[87:72] = '0;
      model_cmd(f, d, ec, er, cm);
      el = (f == 8'h03 && cm != '0) ? 3 : 2;
      send(f, d, 10, code, rd, lat, to);
      if (ec == 8'h00 && f == 8'h03) model_commit(cm);
      n_chk++;
      if (to || code !== ec || rd !== er || lat != el) begin
        n_err++; $display("FAIL rand_resp_%0d: func=%h code=%h data=%h lat=%0d want %h %h %0d",
                          n, f, code, rd, lat, ec, er, el);
      end
      n_chk++;
      if (all_out !== e_all()) begin
        n_err++; $display("FAIL rand_regs_%0d: got %h want %h", n, all_out, e_all());
      end
    end
  endtask

  task automatic test_timeout();
    logic [87:0] d; logic [7:0] ec, code, dcode, tcode; logic [31:0] er, rd, tdata;
    logic [NCH-1:0] cm; logic [AW-1:0] exp_t;
    int lat, dlat, tlat; bit to, dseen, tseen;
    d = rnd_frame(8'd2);
    d[71:64] = act[2].duty ^ 8'hFF;
    model_cmd(8'h01, d, ec, er, cm);
    send(8'h01, d, 10, code, rd, lat, to);
    exp_t = e_all();
    d = rnd_frame(8'h00);
    d[79:72] = 8'h04;
    model_cmd(8'h03, d, ec, er, cm);
    ch_busy_t = 8'h04;
    func_reg = 8'h03; rev_data = d; pack_done = 1'b1;
    @(posedge clk); #1;
    pack_done = 1'b0;
    lat = 1; dseen = 0; tseen = 0; dlat = 0; tlat = 0;
    dcode = 8'hXX; tcode = 8'hXX; tdata = 'x;
    while (!tseen && lat < 400) begin
      if (!dseen && resp_valid) begin
        dseen = 1; dlat = lat; dcode = resp_code;
      end
      if (t_resp_valid) begin
        tseen = 1; tlat = lat; tcode = t_resp_code; tdata = t_resp_data;
      end else begin
        @(posedge clk); #1; lat++;
      end
    end
    @(posedge clk); #1;
    ch_busy_t = '0;
    model_commit(cm);
    n_chk++;
    if (!tseen || tcode !== 8'hE3 || tdata !== 32'h0) begin
      n_err++; $display("FAIL tmo_nak: seen=%b code=%h data=%h want 1 e3 0",
                        tseen, tcode, tdata);
    end
    n_chk++;
    if (tlat < TMO_S + 2 || tlat > TMO_S + 4) begin
      n_err++; $display("FAIL tmo_time: lat=%0d want %0d..%0d",
                        tlat, TMO_S + 2, TMO_S + 4);
    end
    n_chk++;
    if (t_all_out !== exp_t) begin
      n_err++; $display("FAIL tmo_no_commit: got %h want %h", t_all_out, exp_t);
    end
    n_chk++;
    if (!dseen || dcode !== 8'h00 || dlat != 3 || all_out !== e_all()) begin
      n_err++; $display("FAIL tmo_peer_ack: code=%h lat=%0d want 00 3", dcode, dlat);
    end
  endtask

  task automatic test_reset_mid_commit();
    logic [87:0] d; logic [7:0] ec, code; logic [31:0] er, rd;
    logic [NCH-1:0] cm; int lat; bit to;
    d = rnd_frame(8'd3);
    d[71:64] = 8'h5A;
    model_cmd(8'h01, d, ec, er, cm);
    send(8'h01, d, 10, code, rd, lat, to);
    ch_busy = 8'h08;
    d = rnd_frame(8'h00);
    d[79:72] = 8'h08;
    func_reg = 8'h03; rev_data = d; pack_done = 1'b1;
    @(posedge clk); #1;
    pack_done = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_chk++;
    if (cmd_busy !== 1'b1) begin
      n_err++; $display("FAIL mid_commit_busy: got %b want 1", cmd_busy);
    end
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    n_chk++;
    if (all_out !== '0 || {resp_valid, cmd_busy, drop_cnt, resp_code, resp_data} !== '0) begin
      n_err++; $display("FAIL async_reset: regs=%h busy=%b drop=%0d want 0",
                        all_out, cmd_busy, drop_cnt);
    end
    ch_busy = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (all_out !== '0 || resp_valid !== 1'b0 || cmd_busy !== 1'b0) begin
      n_err++; $display("FAIL no_partial_commit: regs=%h valid=%b want 0",
                        all_out, resp_valid);
    end
    d = rnd_frame(8'hFF);
    d[79:72] = 8'hFF;
    model_cmd(8'h03, d, ec, er, cm);
    send(8'h03, d, 10, code, rd, lat, to);
    model_commit(cm);
    n_chk++;
    if (to || code !== 8'h00 || all_out !== e_all()) begin
      n_err++; $display("FAIL shadow_cleared: got %h want %h", all_out, e_all());
    end
  endtask

  initial begin
    test_reset();
    test_set_commit();
    test_errors();
    test_busy_wait();
    test_backpressure();
    test_broadcast_readback();
    test_random();
    test_timeout();
    test_reset_mid_commit();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
